// File: rtl/riscv_defs.sv
// Shared definitions for the memory controller: FSM state encoding, load/store
// size codes and byte-count helpers.
package riscv_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFETCH = 2'd1,
        LOAD   = 2'd2,
        STORE  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 is illegal and behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'd3) ? SZ_W : size;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/load_ext.sv
// Extends the low 1, 2 or 4 bytes of a gathered load word to 32 bits,
// zero- or sign-extending from the top bit of the loaded value.
module load_ext
    import riscv_defs::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] value
);

    always_comb begin
        case (size)
            SZ_B:    value = {{24{is_signed & raw[7]}}, raw[7:0]};
            SZ_H:    value = {{16{is_signed & raw[15]}}, raw[15:0]};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating between instruction fetch and
// load/store traffic, with IO write back-pressure, flush abort and rdy freeze.
module mem_ctrl
    import riscv_defs::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] IO_BASE    = 32'h0003_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [31:0]           if_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [1:0]            ls_size,
    input  logic                  ls_signed,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
    input  logic                  flush,
    output state_t                fsm_state
);

    state_t                state, state_n;
    logic [2:0]            cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] base, base_n, st_addr, mem_a_n;
    logic [1:0]            size_q, size_n;
    logic                  sgn_q, sgn_n;
    logic [31:0]           wdata_q, wdata_n, raw_q, raw_n, raw_cap, ext_value;
    logic [31:0]           if_data_n, ls_rdata_n;
    logic [7:0]            st_byte, mem_dout_n;
    logic [2:0]            nbytes;
    logic                  rd_last, st_go, ls_take, if_take;
    logic                  mem_wr_n, if_valid_n, ls_done_n;

    function automatic logic is_io(input logic [ADDR_WIDTH-1:0] a);
        return a[17:16] == IO_BASE[17:16];
    endfunction

    // A requester whose pulse is currently high is still holding its request.
    assign ls_take = ls_req && !ls_done && (ls_we || !flush);
    assign if_take = if_req && !if_valid && !flush;

    assign nbytes  = size_bytes(size_q);
    assign rd_last = (cnt == nbytes - 3'd1);
    assign st_addr = base + ADDR_WIDTH'(cnt);
    assign st_byte = wdata_q[{cnt[1:0], 3'b000} +: 8];
    assign st_go   = !(is_io(st_addr) && io_buffer_full);

    always_comb begin
        raw_cap = raw_q;
        raw_cap[{cnt[1:0], 3'b000} +: 8] = mem_din;
    end

    load_ext u_load_ext (
        .raw      (raw_cap),
        .size     (size_q),
        .is_signed(sgn_q),
        .value    (ext_value)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (ls_take)      state_n = ls_we ? STORE : LOAD;
                    else if (if_take) state_n = IFETCH;
                end
                IFETCH, LOAD: if (flush || rd_last) state_n = IDLE;
                STORE:        if (cnt == nbytes)    state_n = IDLE;
                default:      state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_n      = cnt;
        base_n     = base;
        size_n     = size_q;
        sgn_n      = sgn_q;
        wdata_n    = wdata_q;
        raw_n      = raw_q;
        mem_a_n    = mem_a;
        mem_dout_n = mem_dout;
        mem_wr_n   = 1'b0;
        if_valid_n = 1'b0;
        if_data_n  = if_data;
        ls_done_n  = 1'b0;
        ls_rdata_n = ls_rdata;
        if (rdy) begin
            case (state)
                IDLE: begin
                    if (ls_take) begin
                        base_n  = ls_addr;
                        size_n  = norm_size(ls_size);
                        sgn_n   = ls_signed;
                        wdata_n = ls_wdata;
                        raw_n   = '0;
                        mem_a_n = ls_addr;
                        cnt_n   = 3'd0;
                        // Byte 0 goes out on the accept edge unless the IO sink is full.
                        if (ls_we && !(is_io(ls_addr) && io_buffer_full)) begin
                            mem_wr_n   = 1'b1;
                            mem_dout_n = ls_wdata[7:0];
                            cnt_n      = 3'd1;
                        end
                    end else if (if_take) begin
                        base_n  = if_addr;
                        size_n  = SZ_W;
                        sgn_n   = 1'b0;
                        raw_n   = '0;
                        mem_a_n = if_addr;
                        cnt_n   = 3'd0;
                    end
                end
                IFETCH, LOAD: begin
                    if (!flush) begin
                        raw_n = raw_cap;
                        if (rd_last) begin
                            if (state == IFETCH) begin
                                if_valid_n = 1'b1;
                                if_data_n  = raw_cap;
                            end else begin
                                ls_done_n  = 1'b1;
                                ls_rdata_n = ext_value;
                            end
                        end else begin
                            cnt_n   = cnt + 3'd1;
                            mem_a_n = mem_a + ADDR_WIDTH'(1);
                        end
                    end
                end
                STORE: begin
                    if (cnt == nbytes) begin
                        ls_done_n = 1'b1;
                    end else if (st_go) begin
                        mem_wr_n   = 1'b1;
                        mem_a_n    = st_addr;
                        mem_dout_n = st_byte;
                        cnt_n      = cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            base     <= '0;
            size_q   <= '0;
            sgn_q    <= 1'b0;
            wdata_q  <= '0;
            raw_q    <= '0;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr   <= 1'b0;
            if_valid <= 1'b0;
            if_data  <= '0;
            ls_done  <= 1'b0;
            ls_rdata <= '0;
        end else begin
            cnt      <= cnt_n;
            base     <= base_n;
            size_q   <= size_n;
            sgn_q    <= sgn_n;
            wdata_q  <= wdata_n;
            raw_q    <= raw_n;
            mem_a    <= mem_a_n;
            mem_dout <= mem_dout_n;
            mem_wr   <= mem_wr_n;
            if_valid <= if_valid_n;
            if_data  <= if_data_n;
            ls_done  <= ls_done_n;
            ls_rdata <= ls_rdata_n;
        end
    end

    assign fsm_state = state;

endmodule
